mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
MBIST sequencer that runs a March C- test on one single-port fault memory instance. It generates the memory's write/read, address and write-data stream, and compares read data in a pipelined checker. It reports pass/fail plus first-failure diagnostics to the test top level. It sits between the BIST top/TAP-side start logic and the memory under test.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width
CAPACITY, 15, highest valid address (memory holds CAPACITY+1 words)
ERR_CNT_WIDTH, 8, width of fail_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start request
busy  out  1  test running
done  out  1  test finished; held until next accepted start or rst
fail  out  1  at least one mismatch; valid when done=1
fail_addr  out  ADDR_WIDTH  address of first mismatch
fail_elem  out  3  March element index (0-5) of first mismatch
fail_data  out  DATA_WIDTH  read data of first mismatch
fail_count  out  ERR_CNT_WIDTH  mismatch count (MBIST_DIAG_EN only, else 0)
mem_we  out  1  to memory write_read (1=write, 0=read)
mem_addr  out  ADDR_WIDTH  to memory address
mem_wdata  out  DATA_WIDTH  to memory wdata
mem_rdata  in  DATA_WIDTH  from memory rdata

Behaviour:
- Reset: all outputs 0, state IDLE. rst mid-run aborts immediately; memory contents are then undefined.
- Memory timing contract: wdata is registered inside the memory, so mem_wdata must lead the matching mem_we/mem_addr by one cycle. Read issued in cycle t returns on mem_rdata in cycle t+2.
- March C- elements (0=all zeros, 1=all ones):
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
  - "up" = 0..CAPACITY; "down" = CAPACITY..0. E0 uses up order.
- One operation issued per cycle, no bubbles. For two-op elements: read addr A in cycle t, write addr A in t+1, next address in t+2.
- mem_wdata always equals the write value of the element owning the next cycle's op. It switches during the last op of the previous element.
- FSM:
  - IDLE: start accepted when not busy → SETUP.
  - SETUP: 1 cycle, mem_wdata=0, mem_we=0 → RUN.
  - RUN: issue ops; after last op of E5 → DRAIN.
  - DRAIN: 2 cycles to retire in-flight reads → DONE.
  - DONE: done=1; start → SETUP (clears done/fail/diag); rst → IDLE.
- busy=1 in SETUP, RUN and DRAIN.
- start while busy: ignored.
- Checker: 2-deep shift of {valid, expected, addr, elem} per read. Compare when the stage-2 valid bit is set.
- First mismatch: capture fail_addr/fail_elem/fail_data and set fail. Later mismatches never overwrite the capture.
- Idle outputs: mem_we=0, mem_addr=0 outside RUN.
- Total cycles from accepted start to done rise: 1 + (10·(CAPACITY+1)) + 2. With defaults this is 163.

Optional Feature:
MBIST_DIAG_EN
- Defined: the run continues after mismatches. fail_count increments per mismatch and saturates at all-ones.
- Undefined: the first mismatch aborts the run.
  - Issuing stops; the FSM goes to DRAIN, discarding compare results of in-flight reads, then to DONE.
  - fail_count is tied to 0.

Test Plan:
- Fault-free memory, start pulse → busy=1 next cycle; done rises exactly 163 cycles after start; fail=0.
- Bit 2 stuck-at-0 at addr 5 → fail=1, fail_elem=2, fail_addr=5, fail_data=8'hFB. Without the macro, done rises earlier than 163 cycles.
- Coupling fault: bit 1 rising at addr 6 sets bit 2 of addr 7 → fail_elem=1, fail_addr=7, fail_data=8'h04.
- rst asserted in cycle 50 of a run → next cycle busy=0, done=0, mem_we=0. A subsequent start then completes fault-free in 163 cycles.
- MBIST_DIAG_EN, bit 2 stuck-at-0 at addrs 3 and 5 → done at cycle 163, fail_count=4, fail_addr=3, fail_elem=2.
- start pulsed while busy → ignored, cycle count unchanged. start in DONE → done drops next cycle and the test reruns.

Source files
------------

// File: rtl/mbist_march_ctrl_if.sv
// Bus bundle between the March C- MBIST sequencer and its surroundings:
// start/status towards the BIST top level, write/read stream towards the
// memory under test, plus first-failure diagnostics.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     fail;
  logic [ADDR_WIDTH-1:0]    fail_addr;
  logic [2:0]               fail_elem;
  logic [DATA_WIDTH-1:0]    fail_data;
  logic [ERR_CNT_WIDTH-1:0] fail_count;
  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  // Sequencer side
  modport master (
    input  start, mem_rdata,
    output busy, done, fail, fail_addr, fail_elem, fail_data, fail_count,
           mem_we, mem_addr, mem_wdata
  );

  // BIST top level / memory side
  modport slave (
    output start, mem_rdata,
    input  busy, done, fail, fail_addr, fail_elem, fail_data, fail_count,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer for one single-port memory.
// Issues one memory operation per cycle, checks read data two cycles later
// in a pipelined comparator and keeps first-failure diagnostics.
// Optional build macro MBIST_DIAG_EN: when defined the run continues past
// mismatches and counts them in fail_count; otherwise the first mismatch
// aborts the run and fail_count reads 0.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int CAPACITY      = 15,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  mbist_march_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

  // Value written by element e (E1/E3 write ones, everything else zeros).
  function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? ALL_ONES : '0;
  endfunction

  // E3/E4 walk the address space downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4);
  endfunction

  // E1..E4 are read-then-write elements.
  function automatic logic elem_two_op(input logic [2:0] e);
    return (e >= 3'd1 && e <= 3'd4);
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [2:0]              r_elem;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_phase;
  logic                    r_drain;

  logic                    r_vld_p1, r_vld_p2;
  logic [DATA_WIDTH-1:0]   r_exp_p1, r_exp_p2;
  logic [ADDR_WIDTH-1:0]   r_addr_p1, r_addr_p2;
  logic [2:0]              r_elem_p1, r_elem_p2;

  logic                    r_fail;
  logic [ADDR_WIDTH-1:0]   r_fail_addr;
  logic [2:0]              r_fail_elem;
  logic [DATA_WIDTH-1:0]   r_fail_data;

  logic                    w_start_acc;
  logic                    w_two, w_down, w_at_end, w_last_op, w_is_write;
  logic                    w_issue_read;
  logic [2:0]              w_elem_nxt;
  logic [ADDR_WIDTH-1:0]   w_end_addr;
  logic                    w_chk_en, w_mismatch, w_abort;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;

  assign w_start_acc  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_two        = elem_two_op(r_elem);
  assign w_down       = elem_down(r_elem);
  assign w_end_addr   = w_down ? '0 : LAST_ADDR;
  assign w_at_end     = (r_addr == w_end_addr);
  assign w_last_op    = w_at_end && (!w_two || r_phase);
  assign w_is_write   = (r_elem == 3'd0) || (w_two && r_phase);
  assign w_issue_read = (r_state == S_RUN) && !w_is_write;
  assign w_elem_nxt   = r_elem + 3'd1;

`ifdef MBIST_DIAG_EN
  logic [ERR_CNT_WIDTH-1:0] r_fail_cnt;
  assign w_chk_en = r_vld_p2;
  assign w_abort  = 1'b0;
`else
  // After the first mismatch, results of reads still in flight are dropped.
  assign w_chk_en = r_vld_p2 && !r_fail;
  assign w_abort  = w_mismatch && (r_state == S_RUN);
`endif
  assign w_mismatch = w_chk_en && (bus.mem_rdata != r_exp_p2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and memory-side outputs
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SETUP;
      S_SETUP: begin
        w_mem_wdata = elem_wval(3'd0);
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_mem_we    = w_is_write;
        w_mem_addr  = r_addr;
        // wdata is registered in the memory, so it leads the write by one op
        w_mem_wdata = elem_wval(w_last_op ? w_elem_nxt : r_elem);
        if (w_abort || (w_last_op && r_elem == 3'd5)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (r_drain) w_state_nxt = S_DONE;
      S_DONE:  if (bus.start) w_state_nxt = S_SETUP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // March element / address / phase sequencing
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_elem  <= '0;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_drain <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_drain <= 1'b0;
      if (w_two && !r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        if (w_last_op) begin
          r_elem <= w_elem_nxt;
          r_addr <= elem_down(w_elem_nxt) ? LAST_ADDR : '0;
        end else begin
          r_addr <= w_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end
      end
    end else if (r_state == S_DRAIN) begin
      r_drain <= 1'b1;
    end
  end

  // Checker pipeline control: p1 = read issued last cycle, p2 = data on rdata now
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue_read;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Checker pipeline data: expected value is what the previous element wrote
  always_ff @(posedge clk) begin
    r_exp_p1  <= elem_wval(r_elem - 3'd1);
    r_addr_p1 <= r_addr;
    r_elem_p1 <= r_elem;
    r_exp_p2  <= r_exp_p1;
    r_addr_p2 <= r_addr_p1;
    r_elem_p2 <= r_elem_p1;
  end

  // First-failure capture; later mismatches never overwrite it
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_data <= '0;
    end else if (w_mismatch) begin
      r_fail <= 1'b1;
      if (!r_fail) begin
        r_fail_addr <= r_addr_p2;
        r_fail_elem <= r_elem_p2;
        r_fail_data <= bus.mem_rdata;
      end
    end
  end

`ifdef MBIST_DIAG_EN
  // Saturating mismatch counter
  always_ff @(posedge clk) begin
    if (rst || w_start_acc)                  r_fail_cnt <= '0;
    else if (w_mismatch && r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
  end
  assign bus.fail_count = r_fail_cnt;
`else
  assign bus.fail_count = '0;
`endif

  assign bus.busy      = (r_state == S_SETUP) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.fail      = r_fail;
  assign bus.fail_addr = r_fail_addr;
  assign bus.fail_elem = r_fail_elem;
  assign bus.fail_data = r_fail_data;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Testbench for mbist_march_ctrl: behavioural single-port memory with
// registered wdata, 2-cycle read latency and injectable stuck-at / coupling
// faults; scoreboard of expected end-of-run results checked on done rise.
module tb_mbist_march_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 15;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW)) bus ();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .ERR_CNT_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model with faults
  logic [DW-1:0] mem   [0:CAP];
  logic [DW-1:0] stuck [0:CAP];
  logic          coup_en = 1'b0;
  logic          mem_clr = 1'b0;
  logic [DW-1:0] wd_q, rd1_q, wr_d;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i <= CAP; i++) mem[i] = '0;
    end else if (bus.mem_we === 1'b1) begin
      wr_d = wd_q & ~stuck[bus.mem_addr];
      if (coup_en && bus.mem_addr == 4'd6 && !mem[6][1] && wr_d[1]) mem[7][2] = 1'b1;
      mem[bus.mem_addr] = wr_d;
    end
    wd_q          <= bus.mem_wdata;
    rd1_q         <= mem[bus.mem_addr];
    bus.mem_rdata <= rd1_q;
  end

  // Scoreboard
  typedef struct {
    logic          fail;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [DW-1:0] data;
    logic [EW-1:0] cnt;
    int            cycles;
    int            start_cyc;
  } exp_t;
  exp_t sbq[$];

  // Monitor: on every done rise pop one expectation and compare
  initial begin
    exp_t e;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && !done_q) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected_done: got done=1 expected no run pending");
        end else begin
          e = sbq.pop_front();
          chk("sb_cycles",     32'(cyc - e.start_cyc), 32'(e.cycles));
          chk("sb_fail",       32'(bus.fail),       32'(e.fail));
          chk("sb_fail_addr",  32'(bus.fail_addr),  32'(e.addr));
          chk("sb_fail_elem",  32'(bus.fail_elem),  32'(e.elem));
          chk("sb_fail_data",  32'(bus.fail_data),  32'(e.data));
          chk("sb_fail_count", 32'(bus.fail_count), 32'(e.cnt));
        end
      end
      done_q = (bus.done === 1'b1);
    end
  end

  task automatic set_faults(input logic [DW-1:0] m3, input logic [DW-1:0] m5, input logic cp);
    for (int i = 0; i <= CAP; i++) stuck[i] = '0;
    stuck[3] = m3;
    stuck[5] = m5;
    coup_en  = cp;
  endtask

  // One full run: clear memory, pulse start, optionally poke start mid-run,
  // push the expected outcome, wait for done with a bound.
  task automatic run_test(input logic efail, input logic [AW-1:0] eaddr,
                          input logic [2:0] eelem, input logic [DW-1:0] edata,
                          input logic [EW-1:0] ecnt, input int ecyc, input int poke);
    exp_t e;
    int n;
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    e.fail = efail; e.addr = eaddr; e.elem = eelem; e.data = edata;
    e.cnt = ecnt; e.cycles = ecyc; e.start_cyc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_after_start", 32'(bus.done), 32'd0);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    set_faults('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_fail",       32'(bus.fail),       32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_fail_count", 32'(bus.fail_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free
    run_test(1'b0, 4'd0, 3'd0, 8'h00, 8'd0, 163, 0);

    // Bit 2 stuck-at-0 at addr 5: first seen by E2 reading ones
    set_faults('0, 8'h04, 1'b0);
`ifdef MBIST_DIAG_EN
    run_test(1'b1, 4'd5, 3'd2, 8'hFB, 8'd2, 163, 0);
`else
    run_test(1'b1, 4'd5, 3'd2, 8'hFB, 8'd0, 64, 0);
`endif

    // Coupling: rising bit 1 of addr 6 sets bit 2 of addr 7, caught by E1 r0
    set_faults('0, '0, 1'b1);
`ifdef MBIST_DIAG_EN
    run_test(1'b1, 4'd7, 3'd1, 8'h04, 8'd1, 163, 0);
`else
    run_test(1'b1, 4'd7, 3'd1, 8'h04, 8'd0, 36, 0);
`endif

    // Bit 2 stuck-at-0 at addrs 3 and 5
    set_faults(8'h04, 8'h04, 1'b0);
`ifdef MBIST_DIAG_EN
    run_test(1'b1, 4'd3, 3'd2, 8'hFB, 8'd4, 163, 0);
`else
    run_test(1'b1, 4'd3, 3'd2, 8'hFB, 8'd0, 60, 0);
`endif

    // Reset mid-run
    set_faults('0, '0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   32'(bus.busy),   32'd0);
    chk("midrst_done",   32'(bus.done),   32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_addr",   32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_test(1'b0, 4'd0, 3'd0, 8'h00, 8'd0, 163, 0);

    // start while busy is ignored
    run_test(1'b0, 4'd0, 3'd0, 8'h00, 8'd0, 163, 20);

    // start while in DONE reruns the test
    chk("in_done_before_rerun", 32'(bus.done), 32'd1);
    run_test(1'b0, 4'd0, 3'd0, 8'h00, 8'd0, 163, 0);

    while (sbq.size() > 0) begin
      void'(sbq.pop_front());
      n_chk++;
      n_err++;
      $display("FAIL sb_pending: got no done expected one more done rise");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
